// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice plus a
// carry flop, processing operands LSB-first at one bit per clock.
// Optional flag logic (ovf, zero) is enabled by defining SERIAL_ADDSUB_FLAGS_EN;
// without it both flag ports are tied to 0.
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [WIDTH-1:0]   sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               accept_c;
    logic               last_c;
    logic               sum_c;
    logic               cout_c;
    logic [WIDTH-1:0]   sr_next_c;

    // Full-adder slice on the current LSBs and the shifted-in accumulator value.
    always_comb begin
        sum_c     = sa[0] ^ sb[0] ^ carry;
        cout_c    = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
        sr_next_c = {sum_c, sr[WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a new request is taken in IDLE and DONE alike.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        last_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CNT_LAST) begin
                    last_c     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept_c   = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand shifters, carry, bit counter and registered results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            co     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept_c) begin
                sa    <= a;
                sb    <= op ? ~b : b;
                carry <= op;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (state == RUN) begin
                sa    <= sa >> 1;
                sb    <= sb >> 1;
                sr    <= sr_next_c;
                carry <= cout_c;
                if (last_c) begin
                    result <= sr_next_c;
                    co     <= cout_c;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef SERIAL_ADDSUB_FLAGS_EN
    // Overflow is carry-in vs carry-out of the MSB slice; both flags load with result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (last_c) begin
            ovf  <= carry ^ cout_c;
            zero <= (sr_next_c == '0);
        end
    end
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): vector table plus
// hand-written sequences for mid-run start, back-to-back and async reset.
module tb_serial_addsub;

    localparam int unsigned WIDTH = 8;
`ifdef SERIAL_ADDSUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             co;
    logic             ovf;
    logic             zero;

    int n_pass;
    int n_total;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .co     (co),
        .ovf    (ovf),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vop;
        logic [7:0] exp_res;
        logic       exp_co;
        logic       exp_ovf;
        logic       exp_zero;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done; returns edges to done and busy cycles.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic top,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        a = ta; b = tb_v; op = top; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int dcount;
        logic early_drop;
        logic res_changed;

        n_pass = 0; n_total = 0;
        vecs[0] = '{8'd100,  8'd27,  1'b0, 8'd127,  1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'd100,  8'd28,  1'b0, 8'h80,   1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF,   8'h01,  1'b0, 8'h00,   1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'd5,    8'd7,   1'b1, 8'hFE,   1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h80,   8'h01,  1'b1, 8'h7F,   1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'd9,    8'd9,   1'b1, 8'h00,   1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h7F,   8'h7F,  1'b0, 8'hFE,   1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'h00,   8'h01,  1'b1, 8'hFF,   1'b0, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        #12;
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_done",   32'(done),   32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_co",     32'(co),     32'd0);
        chk("reset_ovf",    32'(ovf),    32'd0);
        chk("reset_zero",   32'(zero),   32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vop, lat, bc);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd8);
            chk($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
            chk($sformatf("v%0d_co", i), 32'(co), 32'(vecs[i].exp_co));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(FLAGS ? vecs[i].exp_ovf : 1'b0));
            chk($sformatf("v%0d_zero", i), 32'(zero), 32'(FLAGS ? vecs[i].exp_zero : 1'b0));
        end

        // Mid-run start with different operands must be ignored.
        @(negedge clk);
        a = 8'd10; b = 8'd20; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; early_drop = 1'b0;
        while (!done && lat < 20) begin
            if (lat == 3) begin a = 8'd1; b = 8'd1; op = 1'b1; start = 1'b1; end
            if (lat == 4) start = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (!busy && !done) early_drop = 1'b1;
        end
        chk("midrun_latency", 32'(lat), 32'd8);
        chk("midrun_busy_held", 32'(early_drop), 32'd0);
        chk("midrun_result", 32'(result), 32'd30);
        chk("midrun_done", 32'(done), 32'd1);

        // Back-to-back: request during the DONE cycle.
        a = 8'd3; b = 8'd4; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done_drops", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        lat = 0; dcount = 0; res_changed = 1'b0;
        while (!done && lat < 20) begin
            if (result !== 8'd30) res_changed = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_result_held", 32'(res_changed), 32'd0);
        chk("b2b_latency", 32'(lat), 32'd8);
        chk("b2b_result", 32'(result), 32'd7);
        @(posedge clk); #1;
        chk("b2b_single_pulse", 32'(done), 32'd0);

        // Asynchronous reset while bit 4 of 50+60 is in flight.
        @(negedge clk);
        a = 8'd50; b = 8'd60; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        chk("rst_busy",   32'(busy),   32'd0);
        chk("rst_done",   32'(done),   32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_co",     32'(co),     32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        dcount = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("rst_no_done", 32'(dcount), 32'd0);
        do_op(8'd1, 8'd2, 1'b0, lat, bc);
        chk("post_rst_latency", 32'(lat), 32'd8);
        chk("post_rst_busy_cycles", 32'(bc), 32'd8);
        chk("post_rst_result", 32'(result), 32'd3);
        chk("post_rst_co", 32'(co), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial two's-complement adder/subtractor. One full-adder slice plus a carry flip-flop, iterated LSB-first, one bit per clock.
- Sequential counterpart to the combinational ripple-carry datapath: trades latency for area in small arithmetic units.
- Controlled by a start/done handshake. The result is registered and held until the next operation completes.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when not busy
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result/flags valid from this cycle
- result  output  WIDTH  sum/difference, held until next done
- co  output  1  carry out; for subtract, 1 = no borrow (a >= b unsigned)
- ovf  output  1  signed overflow (see Optional Feature)
- zero  output  1  result == 0 (see Optional Feature)

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Port names are clk and reset.
- Reset values: all outputs 0; state IDLE; internal shift registers, carry and counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch a into shift register SA.
  - latch b into SB, or ~b when op=1.
  - carry <= op (supplies the +1 for subtract).
  - cnt <= 0; go to RUN.
- RUN, each edge:
  - s = SA[0]^SB[0]^carry.
  - carry <= majority(SA[0],SB[0],carry).
  - SA, SB shift right one bit.
  - s shifts into the MSB of accumulator SR.
  - cnt increments.
- RUN exit: on the edge processing bit WIDTH-1 (edge E_WIDTH):
  - result <= final SR contents including this bit.
  - co <= carry out of the MSB.
  - flags updated.
  - state goes to DONE.
- DONE: done=1 for exactly this cycle, then IDLE. start is accepted in DONE exactly as in IDLE; this allows back-to-back operations, and done still drops.
- Timing: done is high in the cycle following edge E_WIDTH, i.e. WIDTH edges after start was sampled. busy=1 during RUN cycles only (WIDTH cycles), 0 in IDLE/DONE.
- start while RUN: ignored; operands and op changes have no effect.
- result/co/ovf/zero: change only on the RUN-exit edge or on reset. Never intermediate values.
- cnt width: $clog2(WIDTH); terminal compare at WIDTH-1; no wrap beyond.
- Arithmetic: modulo 2^WIDTH. a-b computed as a + ~b + 1.
- Reset mid-operation: immediate abort; all outputs 0; no done pulse.

Optional Feature:
- Macro: SERIAL_ADDSUB_FLAGS_EN.
- Defined:
  - ovf = carry into MSB XOR carry out of MSB, captured on the last bit.
  - zero = (final result == 0).
  - Both are registered with result.
- Undefined: ovf and zero ports still exist, tied to constant 0; no overflow/zero logic synthesized. co, result and timing are unchanged.

Test Plan:
- WIDTH=8, add 100+27 -> result=127, co=0, ovf=0, zero=0; done exactly 8 edges after start sample; busy high for exactly 8 cycles.
- Add 100+28 -> result=0x80, co=0, ovf=1. Add 0xFF+0x01 -> result=0x00, co=1, ovf=0, zero=1 (flags only with SERIAL_ADDSUB_FLAGS_EN; else ovf=zero=0).
- Subtract 5-7 -> result=0xFE, co=0. Subtract 0x80-0x01 -> result=0x7F, co=1, ovf=1. Subtract 9-9 -> result=0, co=1, zero=1.
- Start 10+20, then pulse start with 1+1 and op=1 mid-RUN -> second request ignored; result=30; single done pulse; busy never drops early.
- Back-to-back: start asserted during the DONE cycle with 3+4 -> accepted; next done 8 edges later with result=7. Previous result=30 holds until then.
- Assert reset asynchronously at bit 4 of 50+60 -> outputs 0 immediately; no done. After release, 1+2 -> result=3 with normal latency.
